// File: rtl/p448_mul_arb_pkg.sv
// Shared types and default sizes for the p448 multiplier-sharing scheduler.
// The stage struct is built from the default widths, so the top-level ID_WIDTH
// and PROD_WIDTH parameters are expected to keep these values.
package p448_mul_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_OP_WIDTH   = 32;
  localparam int DEF_PROD_WIDTH = 2 * DEF_OP_WIDTH;
  localparam int DEF_MUL_LAT    = 1;
  localparam int DEF_ID_WIDTH   = 2;

  typedef logic [DEF_OP_WIDTH-1:0]   op_t;
  typedef logic [DEF_PROD_WIDTH-1:0] prod_t;
  typedef logic [DEF_ID_WIDTH-1:0]   req_id_t;

  // One slot of the result pipeline.
  typedef struct packed {
    logic    valid;
    req_id_t id;
    prod_t   prod;
  } pipe_stage_t;

endpackage

// File: rtl/p448_rr_arbiter.sv
// Rotate-priority round-robin arbiter: the pointer names the requester with
// top priority; after a grant is taken, priority moves to the next index.
module p448_rr_arbiter
  import p448_mul_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_WIDTH = DEF_ID_WIDTH
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                advance,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                grant_any
);

  logic [ID_WIDTH-1:0] ptr_q;
  logic [ID_WIDTH-1:0] ptr_nxt;

  // Scan from the pointer upwards, wrapping, and pick the first active request.
  always_comb begin
    int                  k;
    logic [ID_WIDTH-1:0] idx;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    k         = 0;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = int'(ptr_q) + off;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      idx = ID_WIDTH'(k);
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Priority moves one past the requester that was just served.
  always_comb begin
    ptr_nxt = grant_idx + ID_WIDTH'(1);
    if (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ptr_nxt = '0;
  end

  // Pointer register: holds unless a grant is actually taken.
  always_ff @(posedge ap_clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (ap_rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_nxt;
    end
  end

endmodule

// File: rtl/p448_mul_share_arb.sv
// Shares one external 32x32->64 multiplier among NUM_REQ requesters.
// A round-robin arbiter picks one operand pair per cycle; the product is
// carried through MUL_LAT registered stages and returned tagged with its
// requester index. A stalled response freezes the whole pipeline.
// Optional statistics counters are enabled by defining P448_MUL_ARB_STATS_EN.
module p448_mul_share_arb
  import p448_mul_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int OP_WIDTH   = DEF_OP_WIDTH,
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int MUL_LAT    = DEF_MUL_LAT,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*OP_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*OP_WIDTH-1:0]  req_b,
  output logic [OP_WIDTH-1:0]          mul_din0,
  output logic [OP_WIDTH-1:0]          mul_din1,
  input  logic [PROD_WIDTH-1:0]        mul_dout,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [PROD_WIDTH-1:0]        rsp_prod
`ifdef P448_MUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]        grant_cnt,
  output logic [31:0]                  stall_cnt
`endif
);

  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                grant_any;
  logic                stall;
  logic                accept;

  logic [OP_WIDTH-1:0] last_a_q;
  logic [OP_WIDTH-1:0] last_b_q;
  logic [OP_WIDTH-1:0] sel_a;
  logic [OP_WIDTH-1:0] sel_b;

  pipe_stage_t stage_q [MUL_LAT];
  pipe_stage_t stage_in;

  p448_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A held response blocks everything upstream; nothing is granted during reset.
  assign stall     = stage_q[MUL_LAT-1].valid & ~rsp_ready;
  assign accept    = grant_any & ~stall & ~ap_rst;
  assign req_ready = grant & {NUM_REQ{~stall & ~ap_rst}};

  // Multiplier inputs follow the winner, otherwise park on the last issued pair.
  always_comb begin
    sel_a = last_a_q;
    sel_b = last_b_q;
    if (grant_any) begin
      sel_a = req_a[int'(grant_idx)*OP_WIDTH +: OP_WIDTH];
      sel_b = req_b[int'(grant_idx)*OP_WIDTH +: OP_WIDTH];
    end
  end

  assign mul_din0 = sel_a;
  assign mul_din1 = sel_b;

  // Remember the last issued operands so idle cycles do not toggle the multiplier.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      last_a_q <= '0;
      last_b_q <= '0;
    end else if (accept) begin
      last_a_q <= sel_a;
      last_b_q <= sel_b;
    end
  end

  // Entry for stage 1: a product on an accept, otherwise a bubble.
  always_comb begin
    stage_in = '0;
    if (accept) begin
      stage_in.valid = 1'b1;
      stage_in.id    = req_id_t'(grant_idx);
      stage_in.prod  = prod_t'(mul_dout);
    end
  end

  // Result pipeline: shifts one stage per unstalled cycle, freezes on stall.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      // NOTE: every stage is reset, not just the valid bits, so reset outputs read as zero.
      for (int k = 0; k < MUL_LAT; k++) stage_q[k] <= '0;
    end else if (!stall) begin
      stage_q[0] <= stage_in;
      for (int k = 1; k < MUL_LAT; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign rsp_valid = stage_q[MUL_LAT-1].valid;
  assign rsp_id    = ID_WIDTH'(stage_q[MUL_LAT-1].id);
  assign rsp_prod  = PROD_WIDTH'(stage_q[MUL_LAT-1].prod);

`ifdef P448_MUL_ARB_STATS_EN
  logic [31:0] gcnt_q [NUM_REQ];
  logic [31:0] scnt_q;

  // Event counters: wrap naturally at 2^32.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int k = 0; k < NUM_REQ; k++) gcnt_q[k] <= '0;
      scnt_q <= '0;
    end else begin
      if (accept) gcnt_q[grant_idx] <= gcnt_q[grant_idx] + 32'd1;
      if (stall)  scnt_q <= scnt_q + 32'd1;
    end
  end

  // Flatten the per-requester counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) grant_cnt[k*32 +: 32] = gcnt_q[k];
  end

  assign stall_cnt = scnt_q;
`endif

endmodule
